player_state_tx: RTL and testbench
==================================

Name: player_state_tx

Overview:
- Transmit-side counterpart to the game block's opponent-state receive path.
- Once per video frame, snapshots the local player state: position, direction, game status and reset flag.
- Packs the snapshot into a fixed 7-byte packet and streams it byte-serially over a valid/ready byte interface toward the network/UART framer.
- The remote board's receiver decodes this packet into r_opp_x, r_opp_y, r_opp_dir, r_opp_game and r_opp_rst.

Parameters:
- SYNC_BYTE, 8'hA5, first byte of every packet.
- DROP_W, 8, width of the saturating dropped-trigger counter.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- send_trigger  input  1  single-cycle request to send a snapshot. Top level drives it at hcount==1200 && vcount==800.
- player_x  input  11  local x position.
- player_y  input  11  local y position.
- player_direction  input  9  heading, 0..359.
- game_stat  input  3  local game status.
- local_rst  input  1  local game-reset request flag.
- axiod  output  8  packet byte.
- axiov  output  1  axiod valid.
- axiir  input  1  downstream ready.
- busy  output  1  packet in flight.
- pkt_done  output  1  one-cycle pulse when the last byte is accepted.
- seq  output  4  sequence number of the next packet.
- drop_count  output  DROP_W  triggers ignored because the block was busy.

Behaviour:
- Reset (rst==0, asynchronous):
  - State goes to IDLE.
  - axiov, busy, pkt_done, seq and drop_count all go to 0; axiod goes to 8'h00.
  - Snapshot registers are cleared.
  - Reset mid-packet abandons the packet immediately; no partial resume after reset.
- Snapshot word, 40 bits, MSB first:
  - [39:29] player_x
  - [28:18] player_y
  - [17:9] player_direction
  - [8:6] game_stat
  - [5] local_rst
  - [4:1] seq
  - [0] 1'b0
- Packet bytes:
  - B0 = SYNC_BYTE.
  - B1..B5 = word[39:32], [31:24], [23:16], [15:8], [7:0].
  - B6 = XOR of B0..B5.
- The checksum is computed from the latched snapshot when the trigger is accepted. It does not depend on live inputs.
- FSM states:
  - IDLE: send_trigger==1 latches all inputs and seq, then moves to SEND with byte index 0.
  - SEND: axiov=1 and axiod=B[index]. On axiov&&axiir, index increments. On acceptance of B6:
    - go to IDLE;
    - pulse pkt_done for one cycle (the cycle after acceptance);
    - increment seq, wrapping 15 -> 0.
- Latency: trigger in cycle N gives axiov=1 with B0 in cycle N+1.
- Handshake rules:
  - axiod must stay stable while axiov=1 and axiir=0.
  - axiov is never deasserted mid-packet except by reset.
  - With axiir held high, the 7 bytes go out on 7 consecutive cycles.
- busy is 1 from the cycle after trigger acceptance through the cycle in which B6 is accepted.
- Simultaneous events:
  - send_trigger while busy (including the cycle B6 is accepted) is ignored.
  - An ignored trigger increments drop_count, saturating at all-ones.
  - Input changes during SEND do not affect the packet in flight.
- A new trigger in the first IDLE cycle after pkt_done is accepted normally.

Test Plan:
- Basic packet: reset, inputs x=128, y=100, dir=0, game=0, local_rst=0, axiir=1, pulse trigger.
  - Required: axiod sequence A5 10 01 90 00 00 24 on 7 consecutive axiov cycles.
  - Required: pkt_done pulses once; seq becomes 1.
- Sequence field: repeat the same inputs for a second packet.
  - Required: bytes A5 10 01 90 00 02 26.
  - After 16 packets from reset, seq wraps to 0.
- Backpressure: axiir toggles 1,0,0,1,...
  - Required: axiod is held constant while axiir=0.
  - Required: no byte is skipped or duplicated; packet still ends with the correct checksum.
- Trigger while busy: second trigger pulsed at byte 3, and another on the B6-accept cycle.
  - Required: both ignored; drop_count = 2; exactly one packet output.
  - With DROP_W=2 and 5 dropped triggers, drop_count saturates at 3.
- Snapshot isolation: change player_x to 2000 mid-packet.
  - Required: bytes unchanged from the first-packet values. Next packet B1 = 8'hFA (2000>>3).
- Async reset mid-packet: drive rst low between clock edges during B2.
  - Required: axiov falls immediately without waiting for a clock edge; busy=0, seq=0.
  - After release, the next trigger produces a fresh packet starting with A5.

Source files
------------

// File: rtl/player_state_tx.sv
// Per-frame local player snapshot transmitter: latches position/heading/status on a trigger
// and streams a 7-byte sync+payload+XOR-checksum packet over a byte valid/ready interface.
module player_state_tx #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned DROP_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              send_trigger,
    input  logic [10:0]       player_x,
    input  logic [10:0]       player_y,
    input  logic [8:0]        player_direction,
    input  logic [2:0]        game_stat,
    input  logic              local_rst,
    output logic [7:0]        axiod,
    output logic              axiov,
    input  logic              axiir,
    output logic              busy,
    output logic              pkt_done,
    output logic [3:0]        seq,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [39:0]       r_word;
    logic [2:0]        r_idx;
    logic [3:0]        r_seq;
    logic [DROP_W-1:0] r_drop;
    logic              r_done;

    logic              w_fire;
    logic              w_last;
    logic              w_accept;
    logic              w_drop;
    logic [7:0]        w_csum;
    logic [7:0]        w_byte;

    assign w_fire   = (r_state == ST_SEND) && axiir;
    assign w_last   = w_fire && (r_idx == 3'd6);
    assign w_accept = (r_state == ST_IDLE) && send_trigger;
    assign w_drop   = (r_state == ST_SEND) && send_trigger;

    // Checksum covers only the latched word, so live input changes never reach the packet.
    assign w_csum = SYNC_BYTE ^ r_word[39:32] ^ r_word[31:24] ^ r_word[23:16]
                  ^ r_word[15:8] ^ r_word[7:0];

    always_comb begin
        w_byte = 8'h00;
        case (r_idx)
            3'd0:    w_byte = SYNC_BYTE;
            3'd1:    w_byte = r_word[39:32];
            3'd2:    w_byte = r_word[31:24];
            3'd3:    w_byte = r_word[23:16];
            3'd4:    w_byte = r_word[15:8];
            3'd5:    w_byte = r_word[7:0];
            3'd6:    w_byte = w_csum;
            default: w_byte = 8'h00;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        axiov        = 1'b0;
        axiod        = 8'h00;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (send_trigger) begin
                    w_next_state = ST_SEND;
                end
            end
            ST_SEND: begin
                axiov = 1'b1;
                axiod = w_byte;
                busy  = 1'b1;
                if (w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_word <= '0;
            r_idx  <= '0;
            r_seq  <= '0;
            r_drop <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_word <= {player_x, player_y, player_direction, game_stat, local_rst, r_seq, 1'b0};
                r_idx  <= '0;
            end else if (w_last) begin
                r_idx  <= '0;
            end else if (w_fire) begin
                r_idx  <= r_idx + 3'd1;
            end
            if (w_last) begin
                r_seq <= r_seq + 4'd1;
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + 1'b1;
            end
        end
    end

    assign pkt_done   = r_done;
    assign seq        = r_seq;
    assign drop_count = r_drop;

endmodule

// File: tb/tb_player_state_tx.sv
// Randomized self-checking bench for player_state_tx; expected packets come from the field
// layout and XOR rule, with a second instance exercising a 2-bit drop counter.
module tb_player_state_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        send_trigger;
    logic [10:0] player_x;
    logic [10:0] player_y;
    logic [8:0]  player_direction;
    logic [2:0]  game_stat;
    logic        local_rst;
    logic        axiir;

    logic [7:0]  axiod;
    logic        axiov;
    logic        busy;
    logic        pkt_done;
    logic [3:0]  seq;
    logic [7:0]  drop_count;

    logic [7:0]  s_axiod;
    logic        s_axiov;
    logic        s_busy;
    logic        s_pkt_done;
    logic [3:0]  s_seq;
    logic [1:0]  s_drop;

    int n_cmp = 0;
    int n_err = 0;
    int pkts  = 0;
    int drops = 0;
    logic [7:0] exp_b [7];
    logic [7:0] got_b [7];

    always #5 clk = ~clk;

    player_state_tx #(.SYNC_BYTE(8'hA5), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .send_trigger(send_trigger),
        .player_x(player_x), .player_y(player_y), .player_direction(player_direction),
        .game_stat(game_stat), .local_rst(local_rst),
        .axiod(axiod), .axiov(axiov), .axiir(axiir), .busy(busy),
        .pkt_done(pkt_done), .seq(seq), .drop_count(drop_count)
    );

    player_state_tx #(.SYNC_BYTE(8'hA5), .DROP_W(2)) dut_s (
        .clk(clk), .rst(rst), .send_trigger(send_trigger),
        .player_x(player_x), .player_y(player_y), .player_direction(player_direction),
        .game_stat(game_stat), .local_rst(local_rst),
        .axiod(s_axiod), .axiov(s_axiov), .axiir(axiir), .busy(s_busy),
        .pkt_done(s_pkt_done), .seq(s_seq), .drop_count(s_drop)
    );

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic build_expected(input logic [10:0] x, input logic [10:0] y,
                                  input logic [8:0] dir, input logic [2:0] gs, input logic lr);
        logic [39:0] w;
        logic [3:0]  s;
        logic [7:0]  c;
        s = 4'(pkts % 16);
        w = {x, y, dir, gs, lr, s, 1'b0};
        exp_b[0] = 8'hA5;
        for (int k = 0; k < 5; k++) exp_b[k+1] = w[39-8*k -: 8];
        c = 8'h00;
        for (int k = 0; k < 6; k++) c = c ^ exp_b[k];
        exp_b[6] = c;
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge after the packet completes.
    task automatic run_packet(input logic [10:0] x, input logic [10:0] y, input logic [8:0] dir,
                              input logic [2:0] gs, input logic lr, input int bp_mode,
                              input logic [6:0] trig_mask, input int x_mid_at,
                              input logic [10:0] x_mid, input bit b2b);
        int         idx;
        int         cyc;
        bit         r;
        bit         hold;
        logic [7:0] held;
        player_x = x; player_y = y; player_direction = dir; game_stat = gs; local_rst = lr;
        build_expected(x, y, dir, gs, lr);
        send_trigger = 1'b1;
        @(negedge clk);
        send_trigger = 1'b0;
        idx = 0; cyc = 0; hold = 1'b0; held = 8'h00;
        while (idx < 7 && cyc < 200) begin
            n_cmp++;
            if (axiov !== 1'b1 || busy !== 1'b1) begin
                n_err++;
                $display("FAIL in_flight idx=%0d: axiov=%b busy=%b, required 1 1", idx, axiov, busy);
            end
            if (hold) begin
                n_cmp++;
                if (axiod !== held) begin
                    n_err++;
                    $display("FAIL hold idx=%0d: axiod=%h, required %h", idx, axiod, held);
                end
            end
            case (bp_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = ($urandom_range(1) == 1);
            endcase
            axiir = r;
            if (idx == x_mid_at) player_x = x_mid;
            if (r && trig_mask[idx]) begin
                send_trigger = 1'b1;
                drops++;
            end
            if (r) begin
                got_b[idx] = axiod;
                n_cmp++;
                if (s_axiod !== exp_b[idx]) begin
                    n_err++;
                    $display("FAIL s_byte%0d: got %h, required %h", idx, s_axiod, exp_b[idx]);
                end
                idx++;
            end
            held = axiod;
            hold = !r;
            cyc++;
            @(negedge clk);
            send_trigger = 1'b0;
        end
        axiir = 1'b0;
        if (idx < 7) begin
            n_cmp++; n_err++;
            $display("FAIL timeout: %0d bytes accepted, required 7", idx);
        end else begin
            pkts++;
        end
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (got_b[k] !== exp_b[k]) begin
                n_err++;
                $display("FAIL byte%0d: got %h, required %h", k, got_b[k], exp_b[k]);
            end
        end
        n_cmp++;
        if (pkt_done !== 1'b1 || axiov !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL done: pkt_done=%b axiov=%b busy=%b, required 1 0 0", pkt_done, axiov, busy);
        end
        n_cmp++;
        if (seq !== 4'(pkts % 16) || s_seq !== 4'(pkts % 16) || s_pkt_done !== 1'b1) begin
            n_err++;
            $display("FAIL seq: seq=%0d s_seq=%0d s_done=%b, required %0d 1", seq, s_seq, s_pkt_done, pkts % 16);
        end
        n_cmp++;
        if (drop_count !== 8'(sat(drops, 255)) || s_drop !== 2'(sat(drops, 3))) begin
            n_err++;
            $display("FAIL drop: drop_count=%0d s_drop=%0d, required %0d %0d",
                     drop_count, s_drop, sat(drops, 255), sat(drops, 3));
        end
        if (!b2b) begin
            @(negedge clk);
            n_cmp++;
            if (pkt_done !== 1'b0 || axiov !== 1'b0 || s_busy !== 1'b0) begin
                n_err++;
                $display("FAIL single_pulse: pkt_done=%b axiov=%b s_busy=%b, required 0 0 0", pkt_done, axiov, s_busy);
            end
        end
    endtask

    task automatic rand_packet(input int bp_mode, input bit b2b);
        run_packet(11'($urandom), 11'($urandom), 9'($urandom_range(359)), 3'($urandom),
                   1'($urandom), bp_mode, 7'h00, -1, 11'd0, b2b);
    endtask

    task automatic test_reset();
        rst = 1'b0; send_trigger = 1'b0; axiir = 1'b0;
        player_x = '0; player_y = '0; player_direction = '0; game_stat = '0; local_rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (axiov !== 1'b0 || busy !== 1'b0 || pkt_done !== 1'b0 || seq !== 4'd0 ||
            drop_count !== 8'd0 || axiod !== 8'h00 || s_drop !== 2'd0) begin
            n_err++;
            $display("FAIL reset: axiov=%b busy=%b done=%b seq=%0d drop=%0d axiod=%h, required all 0",
                     axiov, busy, pkt_done, seq, drop_count, axiod);
        end
        rst = 1'b1;
        @(negedge clk);
        pkts = 0; drops = 0;
    endtask

    task automatic test_basic();
        logic [7:0] lit [7];
        lit = '{8'hA5, 8'h10, 8'h01, 8'h90, 8'h00, 8'h00, 8'h24};
        axiir = 1'b1;
        run_packet(11'd128, 11'd100, 9'd0, 3'd0, 1'b0, 0, 7'h00, -1, 11'd0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (got_b[k] !== lit[k]) begin
                n_err++;
                $display("FAIL basic_lit%0d: got %h, required %h", k, got_b[k], lit[k]);
            end
        end
        n_cmp++;
        if (seq !== 4'd1) begin
            n_err++;
            $display("FAIL basic_seq: got %0d, required 1", seq);
        end
    endtask

    task automatic test_seq_field();
        logic [7:0] lit [7];
        lit = '{8'hA5, 8'h10, 8'h01, 8'h90, 8'h00, 8'h02, 8'h26};
        run_packet(11'd128, 11'd100, 9'd0, 3'd0, 1'b0, 0, 7'h00, -1, 11'd0, 1'b0);
        for (int k = 0; k < 7; k++) begin
            n_cmp++;
            if (got_b[k] !== lit[k]) begin
                n_err++;
                $display("FAIL seq_lit%0d: got %h, required %h", k, got_b[k], lit[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        rand_packet(1, 1'b0);
    endtask

    task automatic test_trigger_busy();
        run_packet(11'd1500, 11'd33, 9'd270, 3'd5, 1'b1, 0, 7'b1001000, -1, 11'd0, 1'b0);
        n_cmp++;
        if (drop_count !== 8'd2) begin
            n_err++;
            $display("FAIL trig_busy_drop: got %0d, required 2", drop_count);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (axiov !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL trig_busy_extra: axiov=%b busy=%b, required 0 0", axiov, busy);
        end
    endtask

    task automatic test_drop_saturation();
        run_packet(11'd7, 11'd2047, 9'd359, 3'd7, 1'b0, 0, 7'b0011111, -1, 11'd0, 1'b0);
        n_cmp++;
        if (s_drop !== 2'd3 || drop_count !== 8'd7) begin
            n_err++;
            $display("FAIL drop_sat: s_drop=%0d drop_count=%0d, required 3 7", s_drop, drop_count);
        end
    endtask

    task automatic test_snapshot_isolation();
        run_packet(11'd128, 11'd100, 9'd0, 3'd0, 1'b0, 2, 7'h00, 2, 11'd2000, 1'b0);
        run_packet(11'd2000, 11'd100, 9'd0, 3'd0, 1'b0, 0, 7'h00, -1, 11'd0, 1'b0);
        n_cmp++;
        if (got_b[1] !== 8'hFA) begin
            n_err++;
            $display("FAIL iso_b1: got %h, required fa", got_b[1]);
        end
    endtask

    task automatic test_back_to_back();
        while (pkts < 15) rand_packet(2, ($urandom_range(1) == 1));
        rand_packet(2, 1'b0);
        n_cmp++;
        if (seq !== 4'd0) begin
            n_err++;
            $display("FAIL seq_wrap: got %0d, required 0", seq);
        end
    endtask

    task automatic test_async_reset();
        rand_packet(0, 1'b0);
        player_x = 11'd512; player_y = 11'd9; player_direction = 9'd90; game_stat = 3'd2;
        local_rst = 1'b1;
        build_expected(player_x, player_y, player_direction, game_stat, local_rst);
        send_trigger = 1'b1;
        @(negedge clk);
        send_trigger = 1'b0;
        axiir = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (axiov !== 1'b1 || axiod !== exp_b[2]) begin
            n_err++;
            $display("FAIL pre_reset_b2: axiov=%b axiod=%h, required 1 %h", axiov, axiod, exp_b[2]);
        end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (axiov !== 1'b0 || busy !== 1'b0 || seq !== 4'd0 || drop_count !== 8'd0 || axiod !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset: axiov=%b busy=%b seq=%0d drop=%0d axiod=%h, required 0 0 0 0 00",
                     axiov, busy, seq, drop_count, axiod);
        end
        @(negedge clk);
        rst = 1'b1;
        axiir = 1'b0;
        pkts = 0; drops = 0;
        @(negedge clk);
        rand_packet(0, 1'b0);
        n_cmp++;
        if (got_b[0] !== 8'hA5 || seq !== 4'd1) begin
            n_err++;
            $display("FAIL post_reset: b0=%h seq=%0d, required a5 1", got_b[0], seq);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_seq_field();
        test_backpressure();
        test_trigger_busy();
        test_drop_saturation();
        test_snapshot_isolation();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
